// File: rtl/neighborhood_window.sv
// ============================================================================
// Module   : neighborhood_window
// Purpose  : Streams a raster-ordered binary grid in and emits, for every cell,
//            its 3x3 neighbourhood (centre + 8 neighbours) with out-of-grid
//            positions reading 0. Two line buffers feed a 3x3 shift window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module neighborhood_window #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_cell,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic n,
  output logic ne,
  output logic e,
  output logic se,
  output logic s,
  output logic sw,
  output logic w,
  output logic nw,
  output logic center,
  output logic out_last
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;        // index of the next input cell in the frame
  logic [CW-1:0]    col_in;     // column of the next (real or phantom) input
  logic [RW-1:0]    crow;       // row of the next window centre to emit
  logic [CW-1:0]    ccol;       // column of the next window centre to emit
  logic             ready_en;   // holds in_ready low until the first edge after reset

  // Line buffers: line_a holds the previous row, line_b the row before that.
  logic [WIDTH-1:0] line_a;
  logic [WIDTH-1:0] line_b;

  // 3x3 window rows (top/mid/bottom); bit 2 is the newest (east) column.
  logic [2:0]       win_t;
  logic [2:0]       win_m;
  logic [2:0]       win_b;
  logic [2:0]       nxt_t;
  logic [2:0]       nxt_m;
  logic [2:0]       nxt_b;

  logic out_free;
  logic in_fire;
  logic shift_en;
  logic emit;
  logic pix;
  logic last_xfer;
  logic top_ok;
  logic bot_ok;
  logic west_ok;
  logic east_ok;

  assign out_free  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign last_xfer = out_valid && out_ready && out_last;

  // Phantom inputs during flush are zero (row HEIGHT is outside the grid).
  assign pix = (state == FLUSH) ? 1'b0 : in_cell;

  // Window after the next shift: column read from both line buffers plus the new cell.
  assign nxt_t = {line_b[col_in], win_t[2:1]};
  assign nxt_m = {line_a[col_in], win_m[2:1]};
  assign nxt_b = {pix,            win_b[2:1]};

  // Edge masks come from the centre position, never from buffer contents,
  // so stale rows and the previous row's tail can never leak in.
  assign top_ok  = (crow != '0);
  assign bot_ok  = (crow != RW'(HEIGHT - 1));
  assign west_ok = (ccol != '0);
  assign east_ok = (ccol != CW'(WIDTH - 1));

  // Input handshake depends on the phase of the frame.
  always_comb begin
    in_ready = 1'b0;
    if (ready_en) begin
      case (state)
        FILL:    in_ready = 1'b1;
        RUN:     in_ready = out_free;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Decide when the window advances and when it produces an output.
  always_comb begin
    shift_en = 1'b0;
    emit     = 1'b0;
    case (state)
      FILL: begin
        shift_en = in_fire;
      end
      RUN: begin
        shift_en = in_fire;
        emit     = in_fire;
      end
      FLUSH: begin
        shift_en = out_free && !(out_valid && out_last);
        emit     = shift_en;
      end
      default: begin
        shift_en = 1'b0;
        emit     = 1'b0;
      end
    endcase
  end

  // in_ready enable rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Frame phase FSM with input index and input column tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL;
      idx    <= '0;
      col_in <= '0;
    end else begin
      if (shift_en)
        col_in <= (col_in == CW'(WIDTH - 1)) ? '0 : col_in + CW'(1);
      if (in_fire)
        idx <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
      case (state)
        FILL: begin
          if (in_fire && idx == IW'(WIDTH))
            state <= RUN;
        end
        RUN: begin
          if (in_fire && idx == IW'(N - 1))
            state <= FLUSH;
        end
        FLUSH: begin
          if (last_xfer) begin
            state  <= FILL;
            col_in <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Line buffers and window shift; contents are masked, so no reset needed.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      line_b[col_in] <= line_a[col_in];
      line_a[col_in] <= pix;
      win_t          <= nxt_t;
      win_m          <= nxt_m;
      win_b          <= nxt_b;
    end
  end

  // Centre row/column counters advance once per emitted window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crow <= '0;
      ccol <= '0;
    end else if (emit) begin
      if (ccol == CW'(WIDTH - 1)) begin
        ccol <= '0;
        crow <= (crow == RW'(HEIGHT - 1)) ? '0 : crow + RW'(1);
      end else begin
        ccol <= ccol + CW'(1);
      end
    end
  end

  // Output register: load a masked window on emit, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      center    <= 1'b0;
      n         <= 1'b0;
      ne        <= 1'b0;
      e         <= 1'b0;
      se        <= 1'b0;
      s         <= 1'b0;
      sw        <= 1'b0;
      w         <= 1'b0;
      nw        <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_last  <= (crow == RW'(HEIGHT - 1)) && (ccol == CW'(WIDTH - 1));
      center    <= nxt_m[1];
      n         <= nxt_t[1] & top_ok;
      ne        <= nxt_t[2] & top_ok & east_ok;
      nw        <= nxt_t[0] & top_ok & west_ok;
      e         <= nxt_m[2] & east_ok;
      w         <= nxt_m[0] & west_ok;
      s         <= nxt_b[1] & bot_ok;
      se        <= nxt_b[2] & bot_ok & east_ok;
      sw        <= nxt_b[0] & bot_ok & west_ok;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neighborhood_window.sv
// ============================================================================
// Module   : tb_neighborhood_window
// Purpose  : Self-checking bench for neighborhood_window on a 4x4 grid with a
//            grid-level reference model, random backpressure and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neighborhood_window;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_cell;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic n, ne, e, se, s, sw, w, nw, center, out_last;

  neighborhood_window #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_cell  (in_cell),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .n        (n),
    .ne       (ne),
    .e        (e),
    .se       (se),
    .s        (s),
    .sw       (sw),
    .w        (w),
    .nw       (nw),
    .center   (center),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: grid lookup with out-of-range positions reading 0.
  function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
    return g[r*W + c];
  endfunction

  // Packed as {center,n,ne,e,se,s,sw,w,nw,out_last}.
  function automatic logic [9:0] model(input logic [N-1:0] g, input int k);
    int r;
    int c;
    r = k / W;
    c = k % W;
    return {cell_at(g, r, c),
            cell_at(g, r-1, c),   cell_at(g, r-1, c+1), cell_at(g, r, c+1),
            cell_at(g, r+1, c+1), cell_at(g, r+1, c),   cell_at(g, r+1, c-1),
            cell_at(g, r, c-1),   cell_at(g, r-1, c-1), (k == N-1)};
  endfunction

  logic [9:0] exp_q[$];
  int  rd_idx   = 0;
  int  acc      = 0;
  int  rel_cnt  = 0;
  int  cyc      = 0;
  int  last_cyc = 0;
  bit  in_flush = 0;
  bit  stalled  = 0;
  bit  gap_mode = 0;
  bit  rmode    = 0;
  logic [9:0] cur;
  logic [9:0] prev;

  always @(posedge clk) cyc++;

  // Random or constant downstream readiness.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard, stall stability, flush in_ready, reset behaviour.
  always @(negedge clk) begin
    cur = {center, n, ne, e, se, s, sw, w, nw, out_last};
    if (!rst_n) begin
      check("reset_outputs", {20'd0, out_valid, in_ready, cur}, 32'd0);
      rd_idx   = exp_q.size();
      acc      = 0;
      in_flush = 0;
      stalled  = 0;
      rel_cnt  = 0;
    end else begin
      if (rel_cnt < 3) rel_cnt++;
      if (rel_cnt == 1) check("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
      else if (rel_cnt == 2) check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
      if (stalled) check("stall_hold", {21'd0, out_valid, cur}, {21'd0, 1'b1, prev});
      if (in_flush) check("flush_in_ready", {31'd0, in_ready}, 32'd0);
      if (in_valid && in_ready) begin
        if (acc == 0 && gap_mode) check("b2b_gap", cyc - last_cyc, 32'd1);
        acc++;
        if (acc == N) begin
          acc      = 0;
          in_flush = 1;
        end
      end
      if (out_valid && out_ready) begin
        if (rd_idx < exp_q.size()) begin
          check($sformatf("window%0d", rd_idx), {22'd0, cur}, {22'd0, exp_q[rd_idx]});
          rd_idx++;
        end else begin
          check("extra_window", {22'd0, cur}, 32'hFFFF_FFFF);
        end
        if (out_last) begin
          in_flush = 0;
          last_cyc = cyc;
        end
      end
      stalled = out_valid && !out_ready;
      prev    = cur;
    end
  end

  task automatic push_expected(input logic [N-1:0] g);
    for (int k = 0; k < N; k++) exp_q.push_back(model(g, k));
  endtask

  task automatic send_cells(input logic [N-1:0] g, input int cnt, input bit chk_gap);
    for (int i = 0; i < cnt; i++) begin
      int t;
      in_valid = 1'b1;
      in_cell  = g[i];
      if (i == 0) gap_mode = chk_gap;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 300);
      if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      gap_mode = 1'b0;
    end
    in_valid = 1'b0;
    in_cell  = 1'b0;
  endtask

  task automatic send_frame(input logic [N-1:0] g, input bit chk_gap);
    push_expected(g);
    send_cells(g, N, chk_gap);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (rd_idx < exp_q.size() && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drained", rd_idx, exp_q.size());
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rand_grid();
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = 1'($urandom_range(0, 1));
    return g;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_cell  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All-ones frame, no backpressure.
    rmode = 1'b0;
    send_frame({N{1'b1}}, 1'b0);
    wait_drain();

    // Single live cell at (1,2).
    g = '0;
    g[1*W + 2] = 1'b1;
    send_frame(g, 1'b0);
    wait_drain();

    // Single live cell at (0,3): no east/west wrap into row 1.
    g = '0;
    g[3] = 1'b1;
    send_frame(g, 1'b0);
    wait_drain();

    // Backpressured runs: all-ones plus random frames.
    rmode = 1'b1;
    send_frame({N{1'b1}}, 1'b0);
    wait_drain();
    for (int f = 0; f < 4; f++) begin
      send_frame(rand_grid(), 1'b0);
      wait_drain();
    end
    rmode = 1'b0;
    for (int f = 0; f < 2; f++) begin
      send_frame(rand_grid(), 1'b0);
      wait_drain();
    end

    // Reset mid-frame after 7 inputs, then a clean all-zero frame.
    g = rand_grid() | 16'h0F0F;
    push_expected(g);
    send_cells(g, 7, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_async", {30'd0, out_valid, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame('0, 1'b0);
    wait_drain();

    // Back-to-back frames: all-ones then all-zeros.
    send_frame({N{1'b1}}, 1'b0);
    send_frame('0, 1'b1);
    wait_drain();

    // Back-to-back with backpressure.
    rmode = 1'b1;
    send_frame(rand_grid(), 1'b0);
    send_frame(rand_grid(), 1'b0);
    wait_drain();
    rmode = 1'b0;
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/neighborhood_window.md
NEIGHBORHOOD_WINDOW -- requirements
Module: neighborhood_window

Interface
REQ-001 Parameter WIDTH, default 8, grid columns per row; legal range >= 3.
REQ-002 Parameter HEIGHT, default 8, grid rows per frame; legal range >= 2.
REQ-003 The module SHALL have clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 The module SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have in_valid, input, 1, meaning in_cell is presented.
REQ-006 The module SHALL have in_cell, input, 1, current cell state (1 = alive), in raster order (row 0 col 0 first).
REQ-007 The module SHALL have in_ready, output, 1, meaning the block accepts in_cell this cycle.
REQ-008 The module SHALL have out_valid, output, 1, meaning the window outputs hold a valid neighbourhood.
REQ-009 The module SHALL have out_ready, input, 1, meaning downstream consumes the window this cycle.
REQ-010 The module SHALL have n, ne, e, se, s, sw, w, nw, output, 1 each, the neighbour states of the window centre, directly feeding the 8 popcount inputs.
REQ-011 The module SHALL have center, output, 1, the centre cell state.
REQ-012 The module SHALL have out_last, output, 1, meaning the window is the final cell (HEIGHT-1, WIDTH-1) of the frame.

Function
REQ-013 A beat transfers when valid and ready are both high; all other cycles SHALL leave in/out state unchanged.
REQ-014 The block SHALL hold two WIDTH-bit line buffers plus a 3x3 window shift register, and SHALL use no wrap-around (non-toroidal grid).
REQ-015 The block SHALL track the input cell index i in 0..N-1, where N = WIDTH*HEIGHT, and SHALL wrap i to 0 after N-1.
REQ-016 The window centred on cell k SHALL be produced on the transfer of input i = k+WIDTH+1.
REQ-017 The window SHALL appear on the outputs, with out_valid high, in the cycle after that transfer (1-cycle latency).
REQ-018 Neighbour positions outside the grid SHALL read 0: row -1, row HEIGHT, col -1 and col WIDTH.
REQ-019 Grid edges SHALL be masked from the centre row/column counters and SHALL never take data from the adjacent row's wrap-around.
REQ-020 The FSM SHALL have three states: FILL, RUN, FLUSH.
REQ-021 FILL: in_ready = 1 and out_valid stays 0; on the transfer of i = WIDTH the FSM goes to RUN.
REQ-022 RUN: in_ready = !out_valid || out_ready; each transfer SHALL emit exactly one window.
REQ-023 RUN: on the transfer of i = N-1 the FSM goes to FLUSH.
REQ-024 FLUSH: in_ready = 0; the block SHALL emit the remaining WIDTH+1 windows (centres N-WIDTH-1..N-1), one per cycle whenever the output register is empty or being consumed, shifting 0 in as the phantom input.
REQ-025 FLUSH: when the window with out_last = 1 is consumed, the FSM goes to FILL, and a new frame may be accepted the following cycle.
REQ-026 While out_valid = 1 and out_ready = 0, all outputs SHALL stay stable.
REQ-027 Exactly N windows SHALL be emitted per frame, in raster order, with out_last high on the N-th window only.
REQ-028 Windows SHALL never be dropped or duplicated under any backpressure pattern.

Reset
REQ-029 While rst_n = 0, and immediately on its assertion, the block SHALL force all of the following to 0: out_valid, n..nw, center, out_last, in_ready; it SHALL also set state = FILL, i = 0 and the row/column counters to 0.
REQ-030 Line buffer and shift register contents are don't-care after reset; every read of a not-yet-written position SHALL be masked to 0 by REQ-018.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; after release the next accepted beat is cell (0,0) of a new frame.
REQ-032 in_ready SHALL rise in the first clock edge after rst_n deasserts.

Verification
REQ-033 WIDTH=4, HEIGHT=4, all-ones frame, out_ready=1 -> 16 windows emitted, with these values:
- centre (0,0): e=se=s=1 and all other neighbours 0 (popcount 3);
- centre (1,1): all 8 neighbours 1;
- centre (0,1): 5 ones;
- out_last on window 16 only.
REQ-034 WIDTH=4, HEIGHT=4, single live cell at (1,2) -> exactly 8 windows, (0,1) through (2,3) excluding (1,2), each with one neighbour 1 in the correct direction; the window at (1,2) has center=1 and all neighbours 0.
REQ-035 Column-edge check, single live cell at (0,3) on the 4x4 grid -> window (1,0) has all neighbours 0, proving no east/west wrap.
REQ-036 Random out_ready at 50% duty with continuous in_valid -> the window sequence is identical to the out_ready=1 run; outputs are stable while stalled; in_ready=0 throughout FLUSH.
REQ-037 rst_n pulsed low after 7 inputs of a frame, then a full all-zero 4x4 frame sent -> 16 all-zero windows, with no residue from the aborted frame.
REQ-038 Two back-to-back frames (all-ones, then all-zeros) -> the second frame's window (0,0) is all zeros, and the first input of the second frame is accepted the cycle after the first frame's out_last transfer.
